cfg_chain_loader: RTL and testbench

//  Serialises a word-wide configuration bitstream into the fabric's configuration

---
 rtl/cfg_chain_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
//------------------------------------------------------------------------------
// cfg_chain_loader
//
// Takes configuration words from a valid/ready source and shifts them into the
// CCDFF configuration chain one bit per cycle, LSB first. When the whole chain
// has been filled, it holds the chain enable (cfg_en) high for LATCH_CYCLES
// cycles so every cell captures its bit. It then pulses done for one cycle.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   start, abort    begin a load (IDLE only) / cancel a load in progress
//   s_valid/s_data  bitstream word input, s_ready accepts it
//   cfg_sin         serial data into the chain head
//   cfg_shift_en    chain advances one position
//   cfg_sout        serial data from the chain tail
//   cfg_en          chain latch enable
//   busy, done      status: loading / one-cycle completion pulse
//   bit_count       bits shifted so far, saturating at CHAIN_LEN
//   sout_parity     running XOR of cfg_sout over all shift cycles
//
// Every output is a flop. Its next value is decoded from the next-state values
// of the control registers, so it matches a decode of the current state.
//------------------------------------------------------------------------------
module cfg_chain_loader #(
   parameter int CHAIN_LEN    = 160,
   parameter int WORD_W       = 8,
   parameter int LATCH_CYCLES = 2,
   localparam int CW          = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              cfg_sin,
   output logic              cfg_shift_en,
   input  logic              cfg_sout,
   output logic              cfg_en,
   output logic              busy,
   output logic              done,
   output logic [CW-1:0]     bit_count,
   output logic              sout_parity
);

   localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);
   localparam logic [LW-1:0] LAT_ONE  = LW'(1);
   localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Running parity update for one sampled chain-tail bit.
   function automatic logic parity_step(input logic acc, input logic bit_in);
      return acc ^ bit_in;
   endfunction

   state_t              state_r, state_s;
   logic [WORD_W-1:0]   buf_r, buf_s;
   logic [IW-1:0]       idx_r, idx_s;
   logic                buf_valid_r, buf_valid_s;
   logic [CW-1:0]       cnt_r, cnt_s;
   logic                par_r, par_s;
   logic [LW-1:0]       lat_r, lat_s;

   logic                s_ready_r, s_ready_s;
   logic                cfg_sin_r, cfg_sin_s;
   logic                shift_en_r, shift_en_s;
   logic                cfg_en_r, cfg_en_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;

   // Next-state logic for the FSM, the word buffer and the counters.
   always_comb begin
      state_s     = state_r;
      buf_s       = buf_r;
      idx_s       = idx_r;
      buf_valid_s = buf_valid_r;
      cnt_s       = cnt_r;
      par_s       = par_r;
      lat_s       = lat_r;
      case (state_r)
         ST_IDLE: begin
            // abort blocks a simultaneous start
            if (start && !abort) begin
               state_s     = ST_SHIFT;
               cnt_s       = '0;
               par_s       = 1'b0;
               buf_valid_s = 1'b0;
               idx_s       = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_s     = ST_IDLE;
               buf_valid_s = 1'b0;
               idx_s       = '0;
            end else if (cnt_r >= CNT_FULL) begin
               // Defensive: the chain is already full, go straight to latching
               state_s     = ST_LATCH;
               buf_valid_s = 1'b0;
               idx_s       = '0;
               lat_s       = '0;
            end else if (buf_valid_r) begin
               cnt_s = cnt_r + CNT_ONE;
               par_s = parity_step(par_r, cfg_sout);
               // Buffer drains at the word end or when the chain is full,
               // discarding any unused upper bits of the last word.
               if ((idx_r == IDX_LAST) || (cnt_r == CNT_LAST)) begin
                  buf_valid_s = 1'b0;
                  idx_s       = '0;
               end else begin
                  idx_s = idx_r + IDX_ONE;
               end
               if (cnt_r == CNT_LAST) begin
                  state_s = ST_LATCH;
                  lat_s   = '0;
               end else begin
                  state_s = ST_SHIFT;
               end
            end else if (s_valid && s_ready_r) begin
               buf_s       = s_data;
               buf_valid_s = 1'b1;
               idx_s       = '0;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_LATCH: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (lat_r == LAT_LAST) begin
               state_s = ST_DONE;
            end else begin
               lat_s = lat_r + LAT_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s     = ST_IDLE;
            buf_valid_s = 1'b0;
            idx_s       = '0;
         end
      endcase
   end

   // Output decode from next-state values, registered below.
   always_comb begin
      s_ready_s  = 1'b0;
      cfg_sin_s  = 1'b0;
      shift_en_s = 1'b0;
      cfg_en_s   = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (state_s)
         ST_SHIFT: begin
            busy_s = 1'b1;
            if (buf_valid_s) begin
               shift_en_s = 1'b1;
               cfg_sin_s  = buf_s[idx_s];
            end else begin
               s_ready_s = (cnt_s < CNT_FULL);
            end
         end
         ST_LATCH: begin
            busy_s   = 1'b1;
            cfg_en_s = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         ST_IDLE: begin
            busy_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, buffer, counter and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         buf_r       <= '0;
         idx_r       <= '0;
         buf_valid_r <= 1'b0;
         cnt_r       <= '0;
         par_r       <= 1'b0;
         lat_r       <= '0;
         s_ready_r   <= 1'b0;
         cfg_sin_r   <= 1'b0;
         shift_en_r  <= 1'b0;
         cfg_en_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         buf_r       <= buf_s;
         idx_r       <= idx_s;
         buf_valid_r <= buf_valid_s;
         cnt_r       <= cnt_s;
         par_r       <= par_s;
         lat_r       <= lat_s;
         s_ready_r   <= s_ready_s;
         cfg_sin_r   <= cfg_sin_s;
         shift_en_r  <= shift_en_s;
         cfg_en_r    <= cfg_en_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   assign s_ready      = s_ready_r;
   assign cfg_sin      = cfg_sin_r;
   assign cfg_shift_en = shift_en_r;
   assign cfg_en       = cfg_en_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign bit_count    = cnt_r;
   assign sout_parity  = par_r;

endmodule

// File: tb/tb_cfg_chain_loader.sv
//------------------------------------------------------------------------------
// tb_cfg_chain_loader
//
// Directed bench for a 10-cell chain with 4-bit words and a 2-cycle latch.
// When a word is accepted, its expected chain bits are pushed to a queue. A
// negedge monitor pops one bit per cfg_shift_en cycle and compares it. The
// monitor also drives cfg_sout and keeps a parity model of the bits it drove.
//------------------------------------------------------------------------------
module tb_cfg_chain_loader;

   localparam int CHAIN_LEN    = 10;
   localparam int WORD_W       = 4;
   localparam int LATCH_CYCLES = 2;
   localparam int CW           = $clog2(CHAIN_LEN + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              s_valid = 1'b0;
   logic [WORD_W-1:0] s_data = '0;
   logic              s_ready;
   logic              cfg_sin;
   logic              cfg_shift_en;
   logic              cfg_sout = 1'b0;
   logic              cfg_en;
   logic              busy;
   logic              done;
   logic [CW-1:0]     bit_count;
   logic              sout_parity;

   cfg_chain_loader #(
      .CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .LATCH_CYCLES(LATCH_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .cfg_sin(cfg_sin), .cfg_shift_en(cfg_shift_en), .cfg_sout(cfg_sout),
      .cfg_en(cfg_en), .busy(busy), .done(done),
      .bit_count(bit_count), .sout_parity(sout_parity)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_q[$];
   int   pushed = 0;
   bit   sb_on = 1'b1;
   int   sout_mode = 0;
   int   shift_seen = 0;
   logic model_par = 1'b0;
   int   en_cycles = 0;
   int   done_cnt = 0;
   logic [CHAIN_LEN-1:0] seq = '0;
   int   seq_n = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard pop, cfg_sout drive, latch/done counting.
   always @(negedge clk) begin
      if (!reset) begin
         if (cfg_en) en_cycles++;
         if (done) done_cnt++;
         if (cfg_en || cfg_shift_en) check("en_shift_overlap", {31'd0, cfg_en & cfg_shift_en}, 32'd0);
         if (cfg_shift_en) begin
            logic e;
            logic sb;
            shift_seen++;
            if (sb_on) begin
               if (exp_q.size() == 0) begin
                  check("sin_unexpected_shift", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("cfg_sin", {31'd0, cfg_sin}, {31'd0, e});
               end
               if (seq_n < CHAIN_LEN) seq[seq_n] = cfg_sin;
               seq_n++;
            end
            if (sout_mode == 1) sb = (shift_seen <= 3);
            else sb = 1'($urandom_range(0, 1));
            cfg_sout = sb;
            model_par = model_par ^ sb;
         end else begin
            cfg_sout = 1'b0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check(tag, {21'd0, s_ready, cfg_sin, cfg_shift_en, cfg_en, busy, done, sout_parity, bit_count}, 32'd0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      exp_q.delete();
      pushed = 0; shift_seen = 0; model_par = 1'b0;
      en_cycles = 0; done_cnt = 0; seq = '0; seq_n = 0;
      @(negedge clk);
      start = 1'b0;
      check("start_bit_count", {28'd0, bit_count}, 32'd0);
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_s_ready", {31'd0, s_ready}, 32'd1);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
      bit got = 1'b0;
      s_data = w;
      s_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (s_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) begin
         if (sb_on) begin
            for (int i = 0; i < WORD_W; i++) begin
               if (pushed < CHAIN_LEN) begin
                  exp_q.push_back(w[i]);
                  pushed++;
               end
            end
         end
         @(negedge clk);
         s_valid = 1'b0;
         check("first_bit_latency", {31'd0, cfg_shift_en}, 32'd1);
         repeat (gap) @(negedge clk);
         if (gap >= 5) check("gap_no_shift", {31'd0, cfg_shift_en}, 32'd0);
      end else begin
         s_valid = 1'b0;
         check("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic finish_load(input bit pulse_start, input logic [CHAIN_LEN-1:0] exp_seq);
      bit got = 1'b0;
      bit ready_bad = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (s_ready !== 1'b0) ready_bad = 1'b1;
         start = (pulse_start && cfg_en) ? 1'b1 : 1'b0;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check("done_seen", {31'd0, got}, 32'd1);
      check("s_ready_low_tail", {31'd0, ready_bad}, 32'd0);
      check("done_bit_count", {28'd0, bit_count}, CHAIN_LEN);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_parity", {31'd0, sout_parity}, {31'd0, model_par});
      @(negedge clk);
      check("done_one_pulse", {31'd0, done}, 32'd0);
      check("cfg_en_cycles", en_cycles, LATCH_CYCLES);
      check("done_count", done_cnt, 32'd1);
      check("sb_drained", exp_q.size(), 32'd0);
      check("bit_sequence", {22'd0, seq}, {22'd0, exp_seq});
      check("shift_cycles", seq_n, CHAIN_LEN);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);

      // start and abort together in IDLE: stay idle
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle_busy", {31'd0, busy}, 32'd0);
      check("start_abort_idle_ready", {31'd0, s_ready}, 32'd0);

      // 1: back-to-back words
      do_start();
      send_word(4'hA, 0); send_word(4'h5, 0); send_word(4'h3, 0);
      finish_load(1'b0, 10'b1101011010);

      // 2: 5-cycle gaps between words
      do_start();
      send_word(4'hA, 5); send_word(4'h5, 5); send_word(4'h3, 0);
      finish_load(1'b0, 10'b1101011010);

      // 3: cfg_sout high on the first three shifts only
      sout_mode = 1;
      do_start();
      send_word(4'hA, 0); send_word(4'h5, 0); send_word(4'h3, 0);
      finish_load(1'b0, 10'b1101011010);
      check("parity_first3", {31'd0, sout_parity}, 32'd1);
      sout_mode = 0;

      // 4: abort after 6 bits, then a clean reload
      do_start();
      sb_on = 1'b0;
      send_word(4'hA, 0);
      s_data = 4'h5; s_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (bit_count === CW'(6)) break;
         @(negedge clk);
      end
      s_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bit_count", {28'd0, bit_count}, 32'd6);
      check("abort_ready", {31'd0, s_ready}, 32'd0);
      repeat (6) @(negedge clk);
      check("abort_no_cfg_en", en_cycles, 32'd0);
      check("abort_no_done", done_cnt, 32'd0);
      check("abort_hold_count", {28'd0, bit_count}, 32'd6);
      sb_on = 1'b1;
      do_start();
      send_word(4'h3, 0); send_word(4'hC, 0); send_word(4'hF, 0);
      finish_load(1'b0, 10'b1111000011);

      // 5: start pulses during SHIFT and LATCH are ignored
      do_start();
      send_word(4'hA, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_word(4'h5, 0); send_word(4'h3, 0);
      finish_load(1'b1, 10'b1101011010);

      // 6: asynchronous reset in the middle of SHIFT
      do_start();
      sb_on = 1'b0;
      send_word(4'hA, 0);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset_immediate");
      @(negedge clk);
      #2 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_reset_ready", {31'd0, s_ready}, 32'd0);
      end
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      sb_on = 1'b1;
      do_start();
      send_word(4'hA, 0); send_word(4'h5, 0); send_word(4'h3, 0);
      finish_load(1'b0, 10'b1101011010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
